// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload bundle for one side of a pipeline stage.
// The producer side uses master; the consumer side uses slave.
interface pipe_stage_reg_if #(
    parameter int CTRL_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 3,
    parameter int TAG_W     = 15
);
    logic                          valid;
    logic                          ready;
    logic [CTRL_W-1:0]             ctrl;
    logic [NUM_WORDS*DATA_W-1:0]   data;
    logic [TAG_W-1:0]              tag;

    modport master (output valid, ctrl, data, tag, input ready);
    modport slave  (input valid, ctrl, data, tag, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline register with flush, NOP bubbles, optional skid entry
// and saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int CTRL_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 3,
    parameter int TAG_W     = 15,
    parameter int SKID      = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    pipe_stage_reg_if.slave      up,
    pipe_stage_reg_if.master     dn,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);
    localparam int PW = NUM_WORDS * DATA_W;

    logic              main_v;
    logic [CTRL_W-1:0] main_ctrl;
    logic [PW-1:0]     main_data;
    logic [TAG_W-1:0]  main_tag;
    logic              accept;
    logic              consume;

    assign accept  = up.valid && up.ready;
    assign consume = main_v && dn.ready;

    if (SKID != 0) begin : g_skid
        logic              skid_v;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [PW-1:0]     skid_data;
        logic [TAG_W-1:0]  skid_tag;

        // skid_v is a flop, so in_ready never sees out_ready combinationally
        assign up.ready = !skid_v;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_v    <= 1'b0;
                main_ctrl <= '0;
                main_data <= '0;
                main_tag  <= '0;
                skid_v    <= 1'b0;
                skid_ctrl <= '0;
                skid_data <= '0;
                skid_tag  <= '0;
            end else if (flush) begin
                main_v    <= 1'b0;
                main_ctrl <= '0;
                skid_v    <= 1'b0;
                skid_ctrl <= '0;
            end else if (consume && skid_v) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
                main_tag  <= skid_tag;
                skid_v    <= 1'b0;
                skid_ctrl <= '0;
            end else if (accept && main_v && !consume) begin
                skid_v    <= 1'b1;
                skid_ctrl <= up.ctrl;
                skid_data <= up.data;
                skid_tag  <= up.tag;
            end else if (accept) begin
                main_v    <= 1'b1;
                main_ctrl <= up.ctrl;
                main_data <= up.data;
                main_tag  <= up.tag;
            end else if (consume) begin
                main_v    <= 1'b0;
                main_ctrl <= '0;
            end
        end
    end else begin : g_single
        assign up.ready = !main_v || dn.ready;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                main_v    <= 1'b0;
                main_ctrl <= '0;
                main_data <= '0;
                main_tag  <= '0;
            end else if (flush) begin
                main_v    <= 1'b0;
                main_ctrl <= '0;
            end else if (accept) begin
                main_v    <= 1'b1;
                main_ctrl <= up.ctrl;
                main_data <= up.data;
                main_tag  <= up.tag;
            end else if (consume) begin
                main_v    <= 1'b0;
                main_ctrl <= '0;
            end
        end
    end

    assign dn.valid = main_v;
    assign dn.ctrl  = main_v ? main_ctrl : '0;
    assign dn.data  = main_data;
    assign dn.tag   = main_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_v && !dn.ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (!main_v && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a skid-buffered stage and a single-entry stage (4-bit counters) with
// shared stimulus and compares both against a FIFO-level reference model.
module tb_pipe_stage_reg;
    typedef struct packed {
        logic [7:0]  ctrl;
        logic [95:0] data;
        logic [14:0] tag;
    } pl_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic in_v;
    logic out_rdy;
    pl_t  cur;

    logic [15:0] stall_a, bubble_a;
    logic [3:0]  stall_b, bubble_b;

    int errors = 0;
    int checks = 0;

    pl_t         qa[$];
    pl_t         qb[$];
    logic [95:0] hd_a, hd_b;
    logic [14:0] ht_a, ht_b;
    int unsigned st_a, bu_a, st_b, bu_b;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32), .NUM_WORDS(3), .TAG_W(15)) a_in ();
    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32), .NUM_WORDS(3), .TAG_W(15)) a_out ();
    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32), .NUM_WORDS(3), .TAG_W(15)) b_in ();
    pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32), .NUM_WORDS(3), .TAG_W(15)) b_out ();

    assign a_in.valid  = in_v;
    assign a_in.ctrl   = cur.ctrl;
    assign a_in.data   = cur.data;
    assign a_in.tag    = cur.tag;
    assign b_in.valid  = in_v;
    assign b_in.ctrl   = cur.ctrl;
    assign b_in.data   = cur.data;
    assign b_in.tag    = cur.tag;
    assign a_out.ready = out_rdy;
    assign b_out.ready = out_rdy;

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .NUM_WORDS(3), .TAG_W(15),
                     .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .up(a_in), .dn(a_out),
        .stall_cnt(stall_a), .bubble_cnt(bubble_a));

    pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .NUM_WORDS(3), .TAG_W(15),
                     .SKID(0), .CNT_W(4)) u_single (
        .clk(clk), .rst(rst), .flush(flush), .up(b_in), .dn(b_out),
        .stall_cnt(stall_b), .bubble_cnt(bubble_b));

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        hd_a = '0; hd_b = '0;
        ht_a = '0; ht_b = '0;
        st_a = 0; bu_a = 0; st_b = 0; bu_b = 0;
    endtask

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return (v < max) ? v + 1 : v;
    endfunction

    // One clock edge of the reference: a 2-deep FIFO and a 1-deep FIFO
    task automatic model_edge();
        bit ra, rb, acc, con;
        ra = (qa.size() < 2);
        rb = (qb.size() == 0) || out_rdy;
        if (qa.size() > 0 && !out_rdy) st_a = sat_inc(st_a, 65535);
        if (qa.size() == 0)            bu_a = sat_inc(bu_a, 65535);
        if (qb.size() > 0 && !out_rdy) st_b = sat_inc(st_b, 15);
        if (qb.size() == 0)            bu_b = sat_inc(bu_b, 15);
        if (flush) begin
            qa.delete();
            qb.delete();
        end else begin
            con = (qa.size() > 0) && out_rdy;
            acc = in_v && ra;
            if (con) void'(qa.pop_front());
            if (acc) qa.push_back(cur);
            con = (qb.size() > 0) && out_rdy;
            acc = in_v && rb;
            if (con) void'(qb.pop_front());
            if (acc) qb.push_back(cur);
        end
        if (qa.size() > 0) begin hd_a = qa[0].data; ht_a = qa[0].tag; end
        if (qb.size() > 0) begin hd_b = qb[0].data; ht_b = qb[0].tag; end
    endtask

    task automatic compare_all();
        check_val("a_out_valid", 128'(a_out.valid), 128'(qa.size() > 0));
        check_val("a_out_ctrl",  128'(a_out.ctrl),  128'((qa.size() > 0) ? qa[0].ctrl : 8'h00));
        check_val("a_out_data",  128'(a_out.data),  128'(hd_a));
        check_val("a_out_tag",   128'(a_out.tag),   128'(ht_a));
        check_val("a_in_ready",  128'(a_in.ready),  128'(qa.size() < 2));
        check_val("a_stall_cnt", 128'(stall_a),     128'(st_a));
        check_val("a_bubble_cnt",128'(bubble_a),    128'(bu_a));
        check_val("b_out_valid", 128'(b_out.valid), 128'(qb.size() > 0));
        check_val("b_out_ctrl",  128'(b_out.ctrl),  128'((qb.size() > 0) ? qb[0].ctrl : 8'h00));
        check_val("b_out_data",  128'(b_out.data),  128'(hd_b));
        check_val("b_out_tag",   128'(b_out.tag),   128'(ht_b));
        check_val("b_in_ready",  128'(b_in.ready),  128'((qb.size() == 0) || out_rdy));
        check_val("b_stall_cnt", 128'(stall_b),     128'(st_b));
        check_val("b_bubble_cnt",128'(bubble_b),    128'(bu_b));
    endtask

    task automatic run_cycle(input bit v, input bit ordy, input bit fl, input logic [7:0] ctrl);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        in_v     = v;
        out_rdy  = ordy;
        flush    = fl;
        cur.ctrl = ctrl;
        cur.data = {$urandom(), $urandom(), $urandom()};
        cur.tag  = 15'($urandom());
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_v = 1'b0; out_rdy = 1'b0; cur = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;

        // streaming with a free-running consumer
        run_cycle(1, 1, 0, 8'h11);
        run_cycle(1, 1, 0, 8'h22);
        run_cycle(1, 1, 0, 8'h33);
        run_cycle(0, 1, 0, 8'h00);
        run_cycle(0, 1, 0, 8'h00);

        // back-pressure, then release
        run_cycle(1, 0, 0, 8'h11);
        run_cycle(1, 0, 0, 8'h22);
        for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 8'h33);
        run_cycle(1, 1, 0, 8'h33);
        for (int i = 0; i < 4; i++) run_cycle(0, 1, 0, 8'h00);

        // flush with a simultaneous offer that must be dropped
        run_cycle(1, 0, 0, 8'h55);
        run_cycle(1, 0, 0, 8'h66);
        run_cycle(1, 0, 1, 8'h44);
        run_cycle(0, 1, 0, 8'h00);
        run_cycle(0, 1, 0, 8'h00);

        // out_ready toggling against a valid single entry
        for (int i = 0; i < 8; i++) run_cycle(1, i[0], 0, 8'(8'h70 + i));

        // idle long enough to saturate the 4-bit bubble counter
        for (int i = 0; i < 20; i++) run_cycle(0, 1, 0, 8'h00);

        for (int i = 0; i < 400; i++)
            run_cycle(($urandom % 4) != 0, ($urandom % 3) != 0,
                      ($urandom % 25) == 0, 8'($urandom_range(1, 255)));

        // reset asserted mid-cycle with payloads held
        run_cycle(1, 0, 0, 8'h81);
        run_cycle(1, 0, 0, 8'h82);
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle(1, ($urandom % 2) != 0, 0, 8'(8'h90 + i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
